// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// MMIO map, STATUS bit layout and UART transmitter states.
package dmem_pkg;

    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CYC_LO = 2'd2;
    localparam logic [1:0] REG_CYC_HI = 2'd3;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_CNT   = 4;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_e;

endpackage

// File: rtl/dmem_if.sv
// CPU data-memory bus: load strobe, byte-lane write enables,
// address and store data towards memory, load data back.
interface dmem_if;
    logic        read;
    logic [3:0]  writeb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output read, writeb, addr, wdata,
        input  rdata
    );

    modport slave (
        input  read, writeb, addr, wdata,
        output rdata
    );
endinterface

// File: rtl/uart_tx.sv
// FIFO-buffered 8N1 UART transmitter, LSB first,
// CLK_DIV clocks per bit, back-to-back frames without gaps.
module uart_tx
    import dmem_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_valid_i,
    input  logic [7:0] push_data_i,
    input  logic       ovf_clr_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [3:0] count_o,
    output logic       busy_o,
    output logic       overflow_o,
    output logic       txd_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);
    localparam logic [3:0] DEPTH = 4'(FIFO_DEPTH);

    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [3:0]    cnt_q, cnt_d;
    logic          ovf_q;

    uart_state_e   st_q;
    logic [DW-1:0] div_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic          txd_q;

    logic full, empty, bit_end;
    logic pop, push_ok, ovf_set;
    logic [7:0] head;

    assign full    = (cnt_q == DEPTH);
    assign empty   = (cnt_q == 4'd0);
    assign bit_end = (div_q == DIV_END);
    assign head    = fifo_q[rp_q];

    // Pop on leaving IDLE, or at the end of STOP to chain frames.
    assign pop = !empty &&
                 ((st_q == U_IDLE) ||
                  (st_q == U_STOP && bit_end));

    assign push_ok = push_valid_i && (!full || pop);
    assign ovf_set = push_valid_i && full && !pop;

    assign cnt_d = cnt_q + {3'b0, push_ok} - {3'b0, pop};

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_q[wp_q] <= push_data_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push_ok)
                wp_q <= wp_q + 1'b1;
            if (pop)
                rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_d;
            // Clear has priority over a same-cycle overflow.
            ovf_q <= ovf_clr_i ? 1'b0 : (ovf_q | ovf_set);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q  <= U_IDLE;
            div_q <= '0;
            bit_q <= '0;
            sh_q  <= '0;
            txd_q <= 1'b1;
        end else begin
            unique case (st_q)
                U_IDLE: begin
                    if (pop) begin
                        sh_q  <= head;
                        div_q <= '0;
                        txd_q <= 1'b0;
                        st_q  <= U_START;
                    end
                end
                U_START: begin
                    if (bit_end) begin
                        div_q <= '0;
                        bit_q <= '0;
                        txd_q <= sh_q[0];
                        st_q  <= U_DATA;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                U_DATA: begin
                    if (bit_end) begin
                        div_q <= '0;
                        if (bit_q == 3'd7) begin
                            txd_q <= 1'b1;
                            st_q  <= U_STOP;
                        end else begin
                            sh_q  <= sh_q >> 1;
                            txd_q <= sh_q[1];
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                U_STOP: begin
                    if (bit_end) begin
                        div_q <= '0;
                        if (pop) begin
                            sh_q  <= head;
                            txd_q <= 1'b0;
                            st_q  <= U_START;
                        end else begin
                            st_q  <= U_IDLE;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: begin
                    st_q  <= U_IDLE;
                    txd_q <= 1'b1;
                end
            endcase
        end
    end

    assign full_o     = full;
    assign empty_o    = empty;
    assign count_o    = cnt_q;
    assign busy_o     = (st_q != U_IDLE);
    assign overflow_o = ovf_q;
    assign txd_o      = txd_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: byte-strobed RAM plus MMIO UART and cycle
// counter; combinational reads, writes commit on the rising edge.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter int          CLK_DIV    = 16,
    parameter logic [63:0] CYCLE_INIT = '0
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  dmem,
    output logic   uart_txd,
    output logic   fault
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0] ram_q [RAM_WORDS];
    logic [63:0] cyc_q;
    logic [31:0] hi_q;
    logic        fault_q, fault_d;

    logic          is_mmio, oor, access;
    logic          ram_sel, mmio_sel;
    logic [1:0]    reg_sel;
    logic [AW-1:0] widx;
    logic          push, ovf_clr, snap;

    logic       tx_full, tx_empty, tx_busy, tx_ovf;
    logic [3:0] tx_cnt;
    logic [31:0] status;

    logic unused_ok;
    assign unused_ok = ^dmem.addr[1:0];

    assign is_mmio = |(dmem.addr & MMIO_BASE);
    assign oor = is_mmio ? (|dmem.addr[30:4])
                         : (|dmem.addr[30:AW+2]);
    assign access = dmem.read | (|dmem.writeb);

    assign ram_sel  = !is_mmio && !oor;
    assign mmio_sel = is_mmio && !oor;
    assign reg_sel  = dmem.addr[3:2];
    assign widx     = dmem.addr[AW+1:2];

    assign push = mmio_sel && reg_sel == REG_TXDATA &&
                  dmem.writeb[0];
    assign ovf_clr = mmio_sel && reg_sel == REG_STATUS &&
                     dmem.writeb[0] && dmem.wdata[ST_OVF];
    assign snap = mmio_sel && reg_sel == REG_CYC_LO &&
                  dmem.read;

    assign fault_d = fault_q | (access & oor);

    always_comb begin
        status = '0;
        status[ST_FULL]  = tx_full;
        status[ST_EMPTY] = tx_empty;
        status[ST_BUSY]  = tx_busy;
        status[ST_OVF]   = tx_ovf;
        status[ST_CNT +: 4] = tx_cnt;
    end

    always_comb begin
        dmem.rdata = '0;
        if (ram_sel) begin
            dmem.rdata = ram_q[widx];
        end else if (mmio_sel) begin
            unique case (reg_sel)
                REG_TXDATA: dmem.rdata = '0;
                REG_STATUS: dmem.rdata = status;
                REG_CYC_LO: dmem.rdata = cyc_q[31:0];
                REG_CYC_HI: dmem.rdata = hi_q;
                default:    dmem.rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_sel && dmem.writeb[i])
                ram_q[widx][8*i +: 8] <= dmem.wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q   <= CYCLE_INIT;
            hi_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            cyc_q   <= cyc_q + 64'd1;
            fault_q <= fault_d;
            // Latch the high word with the low read for coherency.
            if (snap)
                hi_q <= cyc_q[63:32];
        end
    end

    uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_uart_tx (
        .clk          (clk),
        .reset        (reset),
        .push_valid_i (push),
        .push_data_i  (dmem.wdata[7:0]),
        .ovf_clr_i    (ovf_clr),
        .full_o       (tx_full),
        .empty_o      (tx_empty),
        .count_o      (tx_cnt),
        .busy_o       (tx_busy),
        .overflow_o   (tx_ovf),
        .txd_o        (uart_txd)
    );

    assign fault = fault_q;

endmodule
